// File: rtl/nexys4_7seg_scanner.sv
// Time-multiplexed driver for common-anode 7-segment digits with frame-synchronous value updates,
// leading-zero suppression and an anode guard window at the start of each digit slot.
module nexys4_7seg_scanner #(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned GUARD_CYCLES   = 16,
    parameter bit          LZ_SUPPRESS    = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dots,
    input  logic [NUM_DIGITS-1:0]     blank,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [7:0]                segs,
    output logic                      frame_tick,
    output logic                      pending
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [DigW-1:0] DigLast = DigW'(NUM_DIGITS - 1);
    localparam logic [DivW-1:0] Guard   = DivW'(GUARD_CYCLES);

    localparam logic [NUM_DIGITS-1:0] AnIdle   = AN_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]            SegsIdle = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [DivW-1:0]         div_q, div_d;
    logic [DigW-1:0]         dig_q, dig_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    pending_q, pending_d;

    logic [4*NUM_DIGITS-1:0] shadow_value_q, shadow_value_d;
    logic [NUM_DIGITS-1:0]   shadow_dots_q, shadow_dots_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [4*NUM_DIGITS-1:0] disp_value_q, disp_value_d;
    logic [NUM_DIGITS-1:0]   disp_dots_q, disp_dots_d;
    logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              segs_q, segs_d;

    logic [NUM_DIGITS-1:0]   suppressed;
    logic [3:0]              nibble;
    logic [6:0]              decoded;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_hot;
    logic [7:0]              segs_hot;

    // Scan counters; frame_tick is registered so it is high while (div, dig) sit on the last slot.
    always_comb begin
        div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
        dig_d = dig_q;
        if (div_q == DivLast) begin
            dig_d = (dig_q == DigLast) ? '0 : dig_q + 1'b1;
        end
        frame_tick_d = (div_d == DivLast) && (dig_d == DigLast);
    end

    always_comb begin
        shadow_value_d = shadow_value_q;
        shadow_dots_d  = shadow_dots_q;
        shadow_blank_d = shadow_blank_q;
        disp_value_d   = disp_value_q;
        disp_dots_d    = disp_dots_q;
        disp_blank_d   = disp_blank_q;
        pending_d      = pending_q;
        if (frame_tick_q) begin
            pending_d = 1'b0;
            if (load) begin
                disp_value_d = value;
                disp_dots_d  = dots;
                disp_blank_d = blank;
            end else if (pending_q) begin
                disp_value_d = shadow_value_q;
                disp_dots_d  = shadow_dots_q;
                disp_blank_d = shadow_blank_q;
            end
        end else if (load) begin
            shadow_value_d = value;
            shadow_dots_d  = dots;
            shadow_blank_d = blank;
            pending_d      = 1'b1;
        end
    end

    // A digit is suppressed when it and every more-significant nibble are zero and it has no dot.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        suppressed = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_value_q[4*i +: 4] == 4'h0);
            if (LZ_SUPPRESS && (i > 0)) begin
                suppressed[i] = zero_run & ~disp_dots_q[i];
            end
        end
    end

    always_comb begin
        nibble = disp_value_q[4*int'(dig_q) +: 4];
        unique case (nibble)
            4'h0: decoded = 7'h7E;
            4'h1: decoded = 7'h30;
            4'h2: decoded = 7'h6D;
            4'h3: decoded = 7'h79;
            4'h4: decoded = 7'h33;
            4'h5: decoded = 7'h5B;
            4'h6: decoded = 7'h5F;
            4'h7: decoded = 7'h70;
            4'h8: decoded = 7'h7F;
            4'h9: decoded = 7'h73;
            4'hA: decoded = 7'h77;
            4'hB: decoded = 7'h1F;
            4'hC: decoded = 7'h4E;
            4'hD: decoded = 7'h3D;
            4'hE: decoded = 7'h4F;
            default: decoded = 7'h47;
        endcase

        dark     = disp_blank_q[dig_q] | suppressed[dig_q] | (div_q < Guard);
        an_hot   = '0;
        segs_hot = 8'h00;
        if (!dark) begin
            an_hot[dig_q] = 1'b1;
            segs_hot      = {disp_dots_q[dig_q], decoded};
        end
        an_d   = AN_ACTIVE_LOW ? ~an_hot : an_hot;
        segs_d = SEG_ACTIVE_LOW ? ~segs_hot : segs_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q          <= '0;
            dig_q          <= '0;
            frame_tick_q   <= 1'b0;
            pending_q      <= 1'b0;
            shadow_value_q <= '0;
            shadow_dots_q  <= '0;
            shadow_blank_q <= '0;
            disp_value_q   <= '0;
            disp_dots_q    <= '0;
            disp_blank_q   <= '0;
            an_q           <= AnIdle;
            segs_q         <= SegsIdle;
        end else begin
            div_q          <= div_d;
            dig_q          <= dig_d;
            frame_tick_q   <= frame_tick_d;
            pending_q      <= pending_d;
            shadow_value_q <= shadow_value_d;
            shadow_dots_q  <= shadow_dots_d;
            shadow_blank_q <= shadow_blank_d;
            disp_value_q   <= disp_value_d;
            disp_dots_q    <= disp_dots_d;
            disp_blank_q   <= disp_blank_d;
            an_q           <= an_d;
            segs_q         <= segs_d;
        end
    end

    assign an         = an_q;
    assign segs       = segs_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_nexys4_7seg_scanner.sv
// Directed bench for nexys4_7seg_scanner: 4 digits, 8-cycle slots, 2-cycle guard window.
module tb_nexys4_7seg_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  blank;
    logic [3:0]  an;
    logic [7:0]  segs;
    logic        frame_tick;
    logic        pending;

    int n_checks = 0;
    int n_fails  = 0;

    nexys4_7seg_scanner #(
        .NUM_DIGITS    (4),
        .SCAN_DIV      (8),
        .GUARD_CYCLES  (2),
        .LZ_SUPPRESS   (1'b1),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .dots      (dots),
        .blank     (blank),
        .an        (an),
        .segs      (segs),
        .frame_tick(frame_tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of a cycle where frame_tick is high.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = frame_tick;
        end
        chk("wait_tick", 32'(seen), 32'd1);
    endtask

    // Entered at the negedge of a frame_tick cycle; checks the next 32 cycles. Cycle c shows the
    // registered result of slot position c-1. s0..s3 are active-high {dp,abcdefg} per digit.
    task automatic check_frame(input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3,
                               input logic [3:0] drk, input int ld_at,
                               input logic [15:0] lv, input logic [3:0] ldt,
                               input logic [3:0] lbl);
        logic [7:0] s [4];
        logic [3:0] exp_an;
        logic [7:0] exp_segs;
        int         dv, dg;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c == ld_at) begin
                load  = 1'b1;
                value = lv;
                dots  = ldt;
                blank = lbl;
            end
            chk($sformatf("frame_tick c=%0d", c), 32'(frame_tick), 32'(c == 31));
            chk($sformatf("pending c=%0d", c), 32'(pending),
                32'((ld_at >= 0) && (ld_at < 31) && (c > ld_at)));
            if (c >= 1) begin
                dv = (c - 1) % 8;
                dg = (c - 1) / 8;
                if (dv < 2 || drk[dg]) begin
                    exp_an   = 4'hF;
                    exp_segs = 8'hFF;
                end else begin
                    exp_an   = ~(4'b0001 << dg);
                    exp_segs = ~s[dg];
                end
                chk($sformatf("an c=%0d", c), 32'(an), 32'(exp_an));
                chk($sformatf("segs c=%0d", c), 32'(segs), 32'(exp_segs));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dots  = 4'h0;
        blank = 4'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset an", 32'(an), 32'hF);
        chk("reset segs", 32'(segs), 32'hFF);
        chk("reset pending", 32'(pending), 32'd0);
        chk("reset frame_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;

        // Initial load before the first frame boundary.
        @(negedge clk);
        load  = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        chk("pending after load", 32'(pending), 32'd1);
        wait_tick();
        chk("pending at first tick", 32'(pending), 32'd1);

        // 1234: digit0..3 = 4,3,2,1
        check_frame(8'h33, 8'h79, 8'h6D, 8'h30, 4'b0000, -1, 16'h0, 4'h0, 4'h0);
        // Mid-frame load of ABCD; old digits persist through this frame.
        check_frame(8'h33, 8'h79, 8'h6D, 8'h30, 4'b0000, 10, 16'hABCD, 4'h0, 4'h0);
        // ABCD shown; load 0042 on the frame_tick cycle.
        check_frame(8'h3D, 8'h4E, 8'h1F, 8'h77, 4'b0000, 31, 16'h0042, 4'b0100, 4'h0);
        // Leading-zero suppression: digit2 keeps its dot, digit3 dark.
        check_frame(8'h6D, 8'h33, 8'hFE, 8'h00, 4'b1000, 31, 16'h1234, 4'h0, 4'b0001);
        // Digit0 blanked.
        check_frame(8'h00, 8'h79, 8'h6D, 8'h30, 4'b0001, -1, 16'h0, 4'h0, 4'h0);

        // Reset asserted in slot 2 with a pending load.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c == 18) begin
                load  = 1'b1;
                value = 16'hABCD;
                blank = 4'h0;
                dots  = 4'h0;
            end
            if (c == 19) begin
                chk("pending before reset", 32'(pending), 32'd1);
                reset = 1'b1;
            end
        end
        @(negedge clk);
        chk("midscan reset an", 32'(an), 32'hF);
        chk("midscan reset segs", 32'(segs), 32'hFF);
        chk("midscan reset pending", 32'(pending), 32'd0);
        chk("midscan reset frame_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;

        // Cleared display: only digit0 shows 0, rest suppressed.
        wait_tick();
        check_frame(8'h7E, 8'h00, 8'h00, 8'h00, 4'b1110, -1, 16'h0, 4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
